// File: rtl/adc_frame_fifo_if.sv
// Sample handshake between the AD sampler / UART consumer and the frame FIFO.
// The master side writes samples and accepts words; the slave side is the FIFO.
interface adc_frame_fifo_if #(
    parameter int DATA_W = 12
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output wr_en, wr_data, wr_last, rd_ready,
        input  rd_data, rd_last, rd_valid
    );

    modport slave (
        input  wr_en, wr_data, wr_last, rd_ready,
        output rd_data, rd_last, rd_valid
    );
endinterface

// File: rtl/adc_frame_fifo.sv
// ADC sample FIFO with frame markers: DEPTH-word RAM, one-word output register,
// drop-or-overwrite overflow handling, and overflow / frame counters.
module adc_frame_fifo #(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 12,
    parameter int AFULL_TH  = (1 << ADDR_W) - 16,
    parameter int AEMPTY_TH = 16,
    parameter int OVF_MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    adc_frame_fifo_if.slave  bus,
    output logic             full,
    output logic             afull,
    output logic [ADDR_W:0]  level,
    output logic             empty,
    output logic             aempty,
    output logic [15:0]      ovf_cnt,
    output logic [15:0]      frame_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   LV_ZERO   = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LV_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_LV  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   ram_q_r;
    logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
    logic [ADDR_W:0]   level_r, level_nx_s;
    logic              q_valid_r, q_valid_nx_s;
    logic              rd_valid_r, rd_valid_nx_s;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_last_r;
    logic              full_r, afull_r, empty_r, aempty_r;
    logic [15:0]       ovf_cnt_r, frame_cnt_r;
    logic              pop_s, wr_acc_s, ovw_s, ovf_ev_s;

    // Per-cycle events: head transfer into the output register, write acceptance, overflow.
    // ram_q_r always holds the RAM head word; q_valid_r says it is a real stored word.
    always_comb begin
        pop_s    = 1'b0;
        wr_acc_s = 1'b0;
        ovw_s    = 1'b0;
        ovf_ev_s = 1'b0;
        if (rst || flush) begin
            pop_s = 1'b0;
        end else begin
            pop_s = q_valid_r && (level_r != LV_ZERO) && (!rd_valid_r || bus.rd_ready);
            if (!bus.wr_en) begin
                wr_acc_s = 1'b0;
            end else if (!full_r) begin
                wr_acc_s = 1'b1;
            end else if (OVF_MODE != 0) begin
                // A same-cycle pop frees a slot, so only a stalled full FIFO loses its oldest word.
                wr_acc_s = 1'b1;
                ovw_s    = !pop_s;
                ovf_ev_s = !pop_s;
            end else begin
                ovf_ev_s = 1'b1;
            end
        end
    end

    // Next-state for pointers, level and the read-ahead / output valid flags.
    always_comb begin
        wr_ptr_nx_s   = wr_ptr_r;
        rd_ptr_nx_s   = rd_ptr_r;
        level_nx_s    = level_r;
        q_valid_nx_s  = 1'b0;
        rd_valid_nx_s = rd_valid_r;
        if (rst || flush) begin
            wr_ptr_nx_s   = PTR_ZERO;
            rd_ptr_nx_s   = PTR_ZERO;
            level_nx_s    = LV_ZERO;
            q_valid_nx_s  = 1'b0;
            rd_valid_nx_s = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nx_s = wr_ptr_r;
            end
            if (pop_s || ovw_s) begin
                rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end
            case ({wr_acc_s && !ovw_s, pop_s})
                2'b10:   level_nx_s = level_r + LV_ONE;
                2'b01:   level_nx_s = level_r - LV_ONE;
                default: level_nx_s = level_r;
            endcase
            // A word written on this same edge is not yet visible to the registered read.
            q_valid_nx_s = (level_r > {{ADDR_W{1'b0}}, pop_s});
            if (pop_s) begin
                rd_valid_nx_s = 1'b1;
            end else if (bus.rd_ready) begin
                rd_valid_nx_s = 1'b0;
            end else begin
                rd_valid_nx_s = rd_valid_r;
            end
        end
    end

    // Sample RAM: write port and registered read-ahead of the next head word.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[wr_ptr_r] <= {bus.wr_last, bus.wr_data};
        end
        ram_q_r <= mem[rd_ptr_nx_s];
    end

    // Control state, output register, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LV_ZERO;
            q_valid_r   <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
            rd_last_r   <= 1'b0;
            ovf_cnt_r   <= 16'h0000;
            frame_cnt_r <= 16'h0000;
            full_r      <= 1'b0;
            afull_r     <= 1'b0;
            empty_r     <= 1'b1;
            aempty_r    <= 1'b1;
        end else begin
            wr_ptr_r   <= wr_ptr_nx_s;
            rd_ptr_r   <= rd_ptr_nx_s;
            level_r    <= level_nx_s;
            q_valid_r  <= q_valid_nx_s;
            rd_valid_r <= rd_valid_nx_s;
            if (pop_s) begin
                rd_data_r <= ram_q_r[DATA_W-1:0];
                rd_last_r <= ram_q_r[DATA_W];
            end
            if (ovf_ev_s && (ovf_cnt_r != 16'hFFFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 16'd1;
            end
            if (wr_acc_s && bus.wr_last) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            full_r   <= (level_nx_s == DEPTH_LV);
            afull_r  <= (level_nx_s >= AFULL_LV);
            aempty_r <= (level_nx_s <= AEMPTY_LV);
            empty_r  <= (level_nx_s == LV_ZERO) && !rd_valid_nx_s;
        end
    end

    assign bus.rd_data  = rd_data_r;
    assign bus.rd_last  = rd_last_r;
    assign bus.rd_valid = rd_valid_r;
    assign full         = full_r;
    assign afull        = afull_r;
    assign level        = level_r;
    assign empty        = empty_r;
    assign aempty       = aempty_r;
    assign ovf_cnt      = ovf_cnt_r;
    assign frame_cnt    = frame_cnt_r;

endmodule
